instr_fetch_queue: RTL and testbench

- Instruction queue between the fetch cache controller and dual-issue decode.
- Buffers 128-bit fetch packets, each holding two instruction/PC pairs, written on the controller's write_fifo strobe.
- Presents the oldest packet to decode in first-word-fall-through style.
- Throttles fetch via stop_fetch and discards all contents on a taken jump.

---
 rtl/instr_fetch_queue.sv | 80 ++++++++
 tb/tb_instr_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers 128-bit dual-instruction fetch packets
// between the fetch cache controller and dual-issue decode. The head packet
// falls through combinationally to decode. stop_fetch throttles the fetch
// side early. A flush from a taken jump discards every queued packet.
module instr_fetch_queue #(
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       write_fifo,
   input  logic [127:0]               fetch_instr_pc,
   input  logic                       flush,
   input  logic                       read_en,
   output logic                       dec_valid,
   output logic [31:0]                dec_instr0,
   output logic [31:0]                dec_pc0,
   output logic [31:0]                dec_instr1,
   output logic [31:0]                dec_pc1,
   output logic                       stop_fetch,
   output logic                       fifo_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][127:0] mem;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic                    rd_fire, wr_fire;
   logic [127:0]            head;

   // A read needs a head packet. A write into a full queue is accepted only
   // when a read frees a slot in the same cycle.
   assign rd_fire = read_en & dec_valid;
   assign wr_fire = write_fifo & ((count < CW'(DEPTH)) | rd_fire);

   // Pointers, occupancy and the sticky drop flag. Flush overrides any
   // same-cycle read or write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
         if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
         if (wr_fire && !rd_fire)      count <= count + CW'(1);
         else if (rd_fire && !wr_fire) count <= count - CW'(1);
         if (write_fifo && !wr_fire) overflow <= 1'b1;
      end
   end

   // Packet storage. It has no reset because the pointers alone decide what
   // is valid. Flush blocks the write, so a packet sent in the flush cycle
   // cannot reappear later.
   always_ff @(posedge clk) begin
      if (wr_fire && !flush) mem[wr_ptr] <= fetch_instr_pc;
   end

   assign head       = mem[rd_ptr];
   assign dec_valid  = (count != '0);
   assign dec_pc0    = dec_valid ? head[31:0]   : 32'h0;
   assign dec_instr0 = dec_valid ? head[63:32]  : 32'h0;
   assign dec_pc1    = dec_valid ? head[95:64]  : 32'h0;
   assign dec_instr1 = dec_valid ? head[127:96] : 32'h0;

   // Back-pressure comes from the registered count. The DEPTH-AF_THRESH
   // slots of headroom absorb packets that are already in flight.
   assign stop_fetch = (count >= CW'(AF_THRESH));
   assign fifo_full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue. The first part is a directed vector table
// that follows the fill, drop, wrap, flush and empty-read sequences. Next
// comes a hand-written asynchronous reset sequence. The last part is a long
// randomized run checked against a queue-based reference model.
module tb_instr_fetch_queue;
   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         write_fifo = 1'b0;
   logic [127:0] fetch_instr_pc = '0;
   logic         flush = 1'b0;
   logic         read_en = 1'b0;
   logic         dec_valid, stop_fetch, fifo_full, overflow;
   logic [31:0]  dec_instr0, dec_pc0, dec_instr1, dec_pc1;
   logic [3:0]   count;

   int tests = 0;
   int fails = 0;

   instr_fetch_queue #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
      .clk(clk), .rst_n(rst_n), .write_fifo(write_fifo),
      .fetch_instr_pc(fetch_instr_pc), .flush(flush), .read_en(read_en),
      .dec_valid(dec_valid), .dec_instr0(dec_instr0), .dec_pc0(dec_pc0),
      .dec_instr1(dec_instr1), .dec_pc1(dec_pc1), .stop_fetch(stop_fetch),
      .fifo_full(fifo_full), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr, rd, fl;
      logic [31:0] pc;
      int          cnt;
      bit          vld;
      logic [31:0] hpc;
      bit          stop, full, ovf;
   } vec_t;

   vec_t tbl[$];

   // Build a packet from pc0 alone, so that every field can be checked.
   function automatic logic [127:0] pk(input logic [31:0] pc0);
      logic [31:0] i0;
      i0 = 32'hA0 + (pc0 >> 3);
      return {pc0 ^ 32'hFFFF_0000, pc0 + 32'd4, i0, pc0};
   endfunction

   function automatic vec_t v(input bit wr, input bit rd, input bit fl,
                              input logic [31:0] pc, input int cnt,
                              input bit vld, input logic [31:0] hpc,
                              input bit stop, input bit full, input bit ovf);
      vec_t r;
      r.wr = wr; r.rd = rd; r.fl = fl; r.pc = pc; r.cnt = cnt; r.vld = vld;
      r.hpc = hpc; r.stop = stop; r.full = full; r.ovf = ovf;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit wr, input bit rd, input bit fl,
                        input logic [31:0] pc);
      write_fifo = wr; read_en = rd; flush = fl; fetch_instr_pc = pk(pc);
   endtask

   function automatic logic [127:0] head_pkt();
      return {dec_instr1, dec_pc1, dec_instr0, dec_pc0};
   endfunction

   // Reference model: a plain queue of packets plus a sticky drop flag.
   logic [127:0] mq[$];
   bit           movf;

   initial begin
      // Directed vectors
      // fill to the almost-full threshold and to full, then drop one write
      tbl.push_back(v(1,0,0,32'h00, 1,1,32'h00,0,0,0));
      tbl.push_back(v(1,0,0,32'h08, 2,1,32'h00,0,0,0));
      tbl.push_back(v(1,0,0,32'h10, 3,1,32'h00,0,0,0));
      tbl.push_back(v(1,0,0,32'h18, 4,1,32'h00,0,0,0));
      tbl.push_back(v(1,0,0,32'h20, 5,1,32'h00,0,0,0));
      tbl.push_back(v(1,0,0,32'h28, 6,1,32'h00,1,0,0));
      tbl.push_back(v(1,0,0,32'h30, 7,1,32'h00,1,0,0));
      tbl.push_back(v(1,0,0,32'h38, 8,1,32'h00,1,1,0));
      tbl.push_back(v(1,0,0,32'h40, 8,1,32'h00,1,1,1));   // dropped
      tbl.push_back(v(1,1,0,32'h48, 8,1,32'h08,1,1,1));   // rd+wr when full
      // drain across the pointer wrap
      tbl.push_back(v(0,1,0,32'h0, 7,1,32'h10,1,0,1));
      tbl.push_back(v(0,1,0,32'h0, 6,1,32'h18,1,0,1));
      tbl.push_back(v(0,1,0,32'h0, 5,1,32'h20,0,0,1));
      tbl.push_back(v(0,1,0,32'h0, 4,1,32'h28,0,0,1));
      tbl.push_back(v(0,1,0,32'h0, 3,1,32'h30,0,0,1));
      tbl.push_back(v(0,1,0,32'h0, 2,1,32'h38,0,0,1));
      tbl.push_back(v(0,1,0,32'h0, 1,1,32'h48,0,0,1));
      tbl.push_back(v(0,1,0,32'h0, 0,0,32'h00,0,0,1));
      // four queued, then flush together with a read and a write
      tbl.push_back(v(1,0,0,32'h100,1,1,32'h100,0,0,1));
      tbl.push_back(v(1,0,0,32'h108,2,1,32'h100,0,0,1));
      tbl.push_back(v(1,0,0,32'h110,3,1,32'h100,0,0,1));
      tbl.push_back(v(1,0,0,32'h118,4,1,32'h100,0,0,1));
      tbl.push_back(v(1,1,1,32'h300,0,0,32'h000,0,0,0));
      tbl.push_back(v(1,0,0,32'h200,1,1,32'h200,0,0,0));
      tbl.push_back(v(0,1,0,32'h0,  0,0,32'h000,0,0,0));
      // read requests on an empty queue are ignored
      tbl.push_back(v(0,1,0,32'h0,  0,0,32'h000,0,0,0));
      tbl.push_back(v(0,1,0,32'h0,  0,0,32'h000,0,0,0));
      tbl.push_back(v(0,1,0,32'h0,  0,0,32'h000,0,0,0));
      tbl.push_back(v(1,0,0,32'h210,1,1,32'h210,0,0,0));
      tbl.push_back(v(0,1,0,32'h0,  0,0,32'h000,0,0,0));

      // Reset state while rst_n is held low
      #2;
      chk("rst count", count, 0);
      chk("rst dec_valid", dec_valid, 0);
      chk("rst stop_fetch", stop_fetch, 0);
      chk("rst fifo_full", fifo_full, 0);
      chk("rst overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         drive(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].pc);
         step();
         chk($sformatf("vec%0d count", i), count, tbl[i].cnt);
         chk($sformatf("vec%0d dec_valid", i), dec_valid, tbl[i].vld);
         chk($sformatf("vec%0d dec_pc0", i), dec_pc0, tbl[i].hpc);
         chk($sformatf("vec%0d dec_instr0", i), dec_instr0,
             tbl[i].vld ? 32'hA0 + (tbl[i].hpc >> 3) : 32'h0);
         chk($sformatf("vec%0d stop_fetch", i), stop_fetch, tbl[i].stop);
         chk($sformatf("vec%0d fifo_full", i), fifo_full, tbl[i].full);
         chk($sformatf("vec%0d overflow", i), overflow, tbl[i].ovf);
      end

      // Asynchronous reset between edges with six packets queued
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, 0, 32'h500 + 32'(k * 8));
         step();
      end
      drive(0, 0, 0, 32'h0);
      chk("pre-areset count", count, 6);
      chk("pre-areset stop_fetch", stop_fetch, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("areset count", count, 0);
      chk("areset dec_valid", dec_valid, 0);
      chk("areset stop_fetch", stop_fetch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 32'h400);
      step();
      chk("post-reset count", count, 1);
      chk("post-reset head", head_pkt(), pk(32'h400));
      drive(0, 1, 0, 32'h0);
      step();
      chk("post-reset drain", count, 0);

      // Randomized run against the queue model
      mq.delete();
      movf = 0;
      for (int i = 0; i < 3000; i++) begin
         bit wr, rd, fl, rf, wf;
         logic [31:0] pc;
         int rd_pct;
         rd_pct = ((i / 300) % 2) ? 25 : 70;
         wr = ($urandom_range(99) < 70);
         rd = ($urandom_range(99) < rd_pct);
         fl = ($urandom_range(99) < 2);
         pc = $urandom & 32'hFFFF_FFF8;
         drive(wr, rd, fl, pc);
         if (fl) begin
            mq.delete();
            movf = 0;
         end else begin
            rf = rd && (mq.size() > 0);
            wf = wr && (mq.size() < DEPTH || rf);
            if (wr && !wf) movf = 1;
            if (rf) void'(mq.pop_front());
            if (wf) mq.push_back(pk(pc));
         end
         step();
         chk($sformatf("rnd%0d count", i), count, mq.size());
         chk($sformatf("rnd%0d dec_valid", i), dec_valid, mq.size() != 0);
         chk($sformatf("rnd%0d stop_fetch", i), stop_fetch, mq.size() >= AF);
         chk($sformatf("rnd%0d fifo_full", i), fifo_full, mq.size() == DEPTH);
         chk($sformatf("rnd%0d overflow", i), overflow, movf);
         chk($sformatf("rnd%0d head", i), head_pkt(),
             (mq.size() != 0) ? mq[0] : 128'h0);
      end
      drive(0, 0, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
